// File: rtl/move_control.sv
// -----------------------------------------------------------------------------
// move_control
//   Control FSM for a single-pixel mover. It draws the pixel, waits one timer
//   period, then erases the pixel and steps it one position in the direction
//   of the highest-priority legal key. The position registers, the colour mux
//   and the timer are in the datapath. This module only drives their enables
//   and selects.
//
// Parameters
//   X_MIN/X_MAX, Y_MIN/Y_MAX : inclusive legal range of xpos / ypos
//
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   restart              : synchronous re-initialise, also clears move_count
//   key_up/down/left/right : level move requests, sampled on timer_done in WAIT
//   timer_done           : move-period tick from the datapath timer
//   xpos, ypos           : current datapath position (used for bound checks)
//   en_xpos, s_xpos      : x register enable / select (0 init, 1 +1, 2 -1)
//   en_ypos, s_ypos      : y register enable / select (0 init, 1 +1, 2 -1)
//   s_color, plot        : colour select (1 red, 0 black) / pixel write strobe
//   en_timer, s_timer    : timer enable / select (1 count, 0 clear)
//   move_count           : completed moves, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module move_control #(
    parameter logic [7:0] X_MIN = 8'd0,
    parameter logic [7:0] X_MAX = 8'd159,
    parameter logic [7:0] Y_MIN = 8'd0,
    parameter logic [7:0] Y_MAX = 8'd119
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        timer_done,
    input  logic [7:0]  xpos,
    input  logic [7:0]  ypos,
    output logic        en_xpos,
    output logic        en_ypos,
    output logic [1:0]  s_xpos,
    output logic [1:0]  s_ypos,
    output logic        s_color,
    output logic        plot,
    output logic        en_timer,
    output logic        s_timer,
    output logic [15:0] move_count
);

    typedef enum logic [2:0] {
        S_INIT,
        S_DRAW,
        S_WAIT,
        S_ERASE,
        S_MOVE
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    localparam logic [1:0] SEL_INIT = 2'd0;
    localparam logic [1:0] SEL_INC  = 2'd1;
    localparam logic [1:0] SEL_DEC  = 2'd2;

    state_t      state, state_nxt;
    dir_t        dir_q, dir_nxt;
    logic [15:0] cnt_q;

    logic up_ok, down_ok, left_ok, right_ok;
    logic move_sel;
    dir_t move_dir;

    // Drop the keys whose move would leave the legal range, then apply priority.
    always_comb begin
        up_ok    = key_up    && (ypos != Y_MIN);
        down_ok  = key_down  && (ypos != Y_MAX);
        left_ok  = key_left  && (xpos != X_MIN);
        right_ok = key_right && (xpos != X_MAX);
        move_sel = up_ok | down_ok | left_ok | right_ok;
        if (up_ok)
            move_dir = DIR_UP;
        else if (down_ok)
            move_dir = DIR_DOWN;
        else if (left_ok)
            move_dir = DIR_LEFT;
        else
            move_dir = DIR_RIGHT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
            dir_q <= DIR_UP;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            dir_q <= dir_nxt;
            if (restart)
                cnt_q <= '0;
            else if ((state == S_MOVE) && (cnt_q != '1))
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign move_count = cnt_q;

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_q;
        en_xpos   = 1'b0;
        en_ypos   = 1'b0;
        s_xpos    = SEL_INIT;
        s_ypos    = SEL_INIT;
        s_color   = 1'b0;
        plot      = 1'b0;
        en_timer  = 1'b0;
        s_timer   = 1'b0;

        case (state)
            S_INIT: begin
                en_xpos   = 1'b1;
                en_ypos   = 1'b1;
                en_timer  = 1'b1;
                state_nxt = S_DRAW;
            end
            S_DRAW: begin
                plot      = 1'b1;
                s_color   = 1'b1;
                en_timer  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                en_timer = 1'b1;
                // The timer is cleared on the tick so the next period starts at once.
                s_timer  = ~timer_done;
                if (timer_done && move_sel) begin
                    dir_nxt   = move_dir;
                    state_nxt = S_ERASE;
                end
            end
            S_ERASE: begin
                plot      = 1'b1;
                state_nxt = S_MOVE;
            end
            S_MOVE: begin
                case (dir_q)
                    DIR_UP:    begin en_ypos = 1'b1; s_ypos = SEL_DEC; end
                    DIR_DOWN:  begin en_ypos = 1'b1; s_ypos = SEL_INC; end
                    DIR_LEFT:  begin en_xpos = 1'b1; s_xpos = SEL_DEC; end
                    DIR_RIGHT: begin en_xpos = 1'b1; s_xpos = SEL_INC; end
                    default:   ;
                endcase
                state_nxt = S_DRAW;
            end
            default: state_nxt = S_INIT;
        endcase

        // restart overrides every transition, including a pending move.
        if (restart) begin
            state_nxt = S_INIT;
            dir_nxt   = dir_q;
        end
    end

endmodule

// File: tb/tb_move_control.sv
// -----------------------------------------------------------------------------
// tb_move_control
//   Self-checking bench for move_control. It includes a small model of the
//   position datapath, which applies the DUT's enables and selects to xpos and
//   ypos. Directed scenarios and a randomized run are compared against a
//   behavioural reference.
// -----------------------------------------------------------------------------
module tb_move_control;

    localparam logic [7:0] XMIN = 8'd0;
    localparam logic [7:0] XMAX = 8'd159;
    localparam logic [7:0] YMIN = 8'd0;
    localparam logic [7:0] YMAX = 8'd119;

    // Packed view: {en_x, s_x[1:0], en_y, s_y[1:0], s_color, plot, en_timer, s_timer}
    localparam logic [10:0] V_INIT  = 11'b1_00_1_00_0_0_1_0;
    localparam logic [10:0] V_DRAW  = 11'b0_00_0_00_1_1_1_0;
    localparam logic [10:0] V_WAIT  = 11'b0_00_0_00_0_0_1_1;
    localparam logic [10:0] V_WAITT = 11'b0_00_0_00_0_0_1_0;
    localparam logic [10:0] V_ERASE = 11'b0_00_0_00_0_1_0_0;
    localparam logic [10:0] V_UP    = 11'b0_00_1_10_0_0_0_0;
    localparam logic [10:0] V_DOWN  = 11'b0_00_1_01_0_0_0_0;
    localparam logic [10:0] V_LEFT  = 11'b1_10_0_00_0_0_0_0;
    localparam logic [10:0] V_RIGHT = 11'b1_01_0_00_0_0_0_0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        restart = 1'b0;
    logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic        timer_done = 1'b0;
    logic [7:0]  xpos = 8'd0, ypos = 8'd0;
    logic [7:0]  x0 = 8'd80, y0 = 8'd80;
    logic        en_xpos, en_ypos, s_color, plot, en_timer, s_timer;
    logic [1:0]  s_xpos, s_ypos;
    logic [15:0] move_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    move_control #(
        .X_MIN(XMIN),
        .X_MAX(XMAX),
        .Y_MIN(YMIN),
        .Y_MAX(YMAX)
    ) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .timer_done(timer_done), .xpos(xpos), .ypos(ypos),
        .en_xpos(en_xpos), .en_ypos(en_ypos), .s_xpos(s_xpos), .s_ypos(s_ypos),
        .s_color(s_color), .plot(plot), .en_timer(en_timer), .s_timer(s_timer),
        .move_count(move_count)
    );

    // Datapath model. The enables are sampled at the edge and the registers
    // are updated just after it, so the DUT always sees a stable position.
    logic       dp_ex, dp_ey;
    logic [1:0] dp_sx, dp_sy;
    always begin
        @(posedge clk);
        dp_ex = en_xpos; dp_sx = s_xpos;
        dp_ey = en_ypos; dp_sy = s_ypos;
        #1;
        if (dp_ex) xpos = (dp_sx == 2'd0) ? x0 : (dp_sx == 2'd1) ? xpos + 8'd1 : xpos - 8'd1;
        if (dp_ey) ypos = (dp_sy == 2'd0) ? y0 : (dp_sy == 2'd1) ? ypos + 8'd1 : ypos - 8'd1;
    end

    function automatic logic [10:0] outv();
        return {en_xpos, s_xpos, en_ypos, s_ypos, s_color, plot, en_timer, s_timer};
    endfunction

    // Reference direction choice: drop out-of-range keys, then up > down > left > right.
    function automatic int pick(input logic u, input logic d, input logic l, input logic r,
                                input logic [7:0] x, input logic [7:0] y);
        if (u && y != YMIN) return 0;
        if (d && y != YMAX) return 1;
        if (l && x != XMIN) return 2;
        if (r && x != XMAX) return 3;
        return -1;
    endfunction

    // Reference outputs per phase (0 init, 1 draw, 2 wait, 3 erase, 4 move).
    function automatic logic [10:0] model_out(input int ph, input int dir, input logic td);
        case (ph)
            0: return V_INIT;
            1: return V_DRAW;
            2: return td ? V_WAITT : V_WAIT;
            3: return V_ERASE;
            default: case (dir)
                0: return V_UP;
                1: return V_DOWN;
                2: return V_LEFT;
                default: return V_RIGHT;
            endcase
        endcase
    endfunction

    task automatic set_keys(input logic u, input logic d, input logic l, input logic r);
        key_up = u; key_down = d; key_left = l; key_right = r;
    endtask

    // Stimulus only: reset, release, and step through INIT and DRAW into WAIT.
    task automatic reset_to_wait();
        @(negedge clk);
        reset = 1'b1; restart = 1'b0; timer_done = 1'b0;
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (outv() !== V_INIT) begin
            n_bad++; $display("FAIL reset_outputs: got %b want %b", outv(), V_INIT);
        end
        n_cmp++;
        if (move_count !== 16'd0) begin
            n_bad++; $display("FAIL reset_count: got %h want 0000", move_count);
        end
        @(negedge clk) reset = 1'b0;
        #1;
        n_cmp++;
        if (outv() !== V_INIT) begin
            n_bad++; $display("FAIL first_init: got %b want %b", outv(), V_INIT);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (outv() !== V_DRAW) begin
            n_bad++; $display("FAIL first_draw: got %b want %b", outv(), V_DRAW);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (outv() !== V_WAIT || move_count !== 16'd0) begin
                n_bad++; $display("FAIL idle_wait[%0d]: got %b/%h want %b/0000", i, outv(), move_count, V_WAIT);
            end
        end
    endtask

    task automatic test_move_right();
        logic [10:0] seq [4];
        seq = '{V_WAITT, V_ERASE, V_RIGHT, V_DRAW};
        x0 = 8'd80; y0 = 8'd80;
        reset_to_wait();
        set_keys(1'b0, 1'b0, 1'b0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                if (i > 0) @(negedge clk);
                timer_done = (i == 0);
                #1;
                n_cmp++;
                if (outv() !== seq[i]) begin
                    n_bad++; $display("FAIL right_seq[%0d][%0d]: got %b want %b", m, i, outv(), seq[i]);
                end
            end
            n_cmp++;
            if (move_count !== 16'(m + 1) || xpos !== 8'(81 + m)) begin
                n_bad++; $display("FAIL right_count[%0d]: got %h x=%0d want %h x=%0d",
                                  m, move_count, xpos, 16'(m + 1), 81 + m);
            end
            @(negedge clk); #1;
            n_cmp++;
            if (outv() !== V_WAIT) begin
                n_bad++; $display("FAIL right_back_wait[%0d]: got %b want %b", m, outv(), V_WAIT);
            end
        end
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        logic [10:0] want;
        x0 = 8'd80; y0 = 8'd80;
        reset_to_wait();
        for (int k = 0; k < 2; k++) begin
            ypos = (k == 0) ? YMIN : 8'd5;
            want = (k == 0) ? V_LEFT : V_UP;
            set_keys(1'b1, 1'b0, 1'b1, 1'b0);
            timer_done = 1'b1;
            @(negedge clk) timer_done = 1'b0;
            @(negedge clk); #1;
            n_cmp++;
            if (outv() !== want) begin
                n_bad++; $display("FAIL priority[%0d]: got %b want %b", k, outv(), want);
            end
            set_keys(1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_bound();
        x0 = 8'd80; y0 = 8'd80;
        reset_to_wait();
        xpos = XMAX;
        set_keys(1'b0, 1'b0, 1'b0, 1'b1);
        timer_done = 1'b1;
        #1;
        n_cmp++;
        if (outv() !== V_WAITT) begin
            n_bad++; $display("FAIL bound_tick: got %b want %b", outv(), V_WAITT);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk) timer_done = 1'b0;
            #1;
            n_cmp++;
            if (outv() !== V_WAIT || move_count !== 16'd0) begin
                n_bad++; $display("FAIL bound_stay[%0d]: got %b/%h want %b/0000", i, outv(), move_count, V_WAIT);
            end
        end
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_restart();
        x0 = 8'd80; y0 = 8'd80;
        reset_to_wait();
        set_keys(1'b0, 1'b1, 1'b0, 1'b0);
        timer_done = 1'b1;
        @(negedge clk) timer_done = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (outv() !== V_DOWN) begin
            n_bad++; $display("FAIL restart_premove: got %b want %b", outv(), V_DOWN);
        end
        @(negedge clk);
        @(negedge clk); #1;
        n_cmp++;
        if (move_count !== 16'd1 || ypos !== 8'd81) begin
            n_bad++; $display("FAIL restart_precount: got %h y=%0d want 0001 y=81", move_count, ypos);
        end
        timer_done = 1'b1;
        restart = 1'b1;
        @(negedge clk);
        timer_done = 1'b0; restart = 1'b0;
        #1;
        n_cmp++;
        if (outv() !== V_INIT || move_count !== 16'd0) begin
            n_bad++; $display("FAIL restart_init: got %b/%h want %b/0000", outv(), move_count, V_INIT);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (outv() !== V_DRAW) begin
            n_bad++; $display("FAIL restart_draw: got %b want %b", outv(), V_DRAW);
        end
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        logic [15:0] want;
        x0 = 8'd80; y0 = 8'd80;
        reset_to_wait();
        #1;
        force dut.cnt_q = 16'hFFFC;
        #1;
        release dut.cnt_q;
        #1;
        n_cmp++;
        if (move_count !== 16'hFFFC) begin
            n_bad++; $display("FAIL sat_preload: got %h want fffc", move_count);
        end
        for (int m = 0; m < 5; m++) begin
            set_keys(1'b0, 1'b0, (m % 2) == 1, (m % 2) == 0);
            timer_done = 1'b1;
            @(negedge clk) timer_done = 1'b0;
            @(negedge clk);
            @(negedge clk); #1;
            want = (32'hFFFC + m + 1 > 32'hFFFF) ? 16'hFFFF : 16'(32'hFFFC + m + 1);
            n_cmp++;
            if (move_count !== want) begin
                n_bad++; $display("FAIL sat_count[%0d]: got %h want %h", m, move_count, want);
            end
            @(negedge clk);
        end
        set_keys(1'b0, 1'b0, 1'b0, 1'b1);
        timer_done = 1'b1;
        @(negedge clk) timer_done = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (outv() !== V_RIGHT) begin
            n_bad++; $display("FAIL abort_in_move: got %b want %b", outv(), V_RIGHT);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (outv() !== V_INIT || move_count !== 16'd0) begin
            n_bad++; $display("FAIL abort_reset: got %b/%h want %b/0000", outv(), move_count, V_INIT);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (outv() !== V_INIT) begin
            n_bad++; $display("FAIL abort_hold: got %b want %b", outv(), V_INIT);
        end
        reset = 1'b0;
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int          ph, dir, p;
        logic [15:0] cnt;
        logic [10:0] want;
        x0 = 8'd2; y0 = 8'd1;
        @(negedge clk) reset = 1'b1;
        restart = 1'b0; timer_done = 1'b0;
        ph = 0; dir = 0; cnt = 16'd0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (i == 0) reset = 1'b0;
            set_keys(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            timer_done = ($urandom_range(0, 3) == 0);
            restart    = ($urandom_range(0, 63) == 0);
            #1;
            want = model_out(ph, dir, timer_done);
            n_cmp++;
            if (outv() !== want) begin
                n_bad++; $display("FAIL rand_out[%0d]: got %b want %b", i, outv(), want);
            end
            n_cmp++;
            if (move_count !== cnt) begin
                n_bad++; $display("FAIL rand_count[%0d]: got %h want %h", i, move_count, cnt);
            end
            if (restart) begin
                ph = 0; cnt = 16'd0;
            end else begin
                case (ph)
                    0: ph = 1;
                    1: ph = 2;
                    2: if (timer_done) begin
                        p = pick(key_up, key_down, key_left, key_right, xpos, ypos);
                        if (p >= 0) begin dir = p; ph = 3; end
                    end
                    3: ph = 4;
                    default: begin
                        ph = 1;
                        if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
                    end
                endcase
            end
        end
        restart = 1'b0; timer_done = 1'b0;
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_move_right();
        test_priority();
        test_bound();
        test_restart();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/move_control.md
MOVE_CONTROL -- requirements
Module: move_control

Interface
REQ-001 The module SHALL have parameter X_MIN, default 8'd0, meaning the lowest legal xpos.
REQ-002 The module SHALL have parameter X_MAX, default 8'd159, meaning the highest legal xpos.
REQ-003 The module SHALL have parameter Y_MIN, default 8'd0, meaning the lowest legal ypos.
REQ-004 The module SHALL have parameter Y_MAX, default 8'd119, meaning the highest legal ypos.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port restart, input, 1 bit: synchronous request to re-initialise the position.
REQ-008 The module SHALL have ports key_up, key_down, key_left and key_right, each input, 1 bit: level-sensitive move requests.
REQ-009 The module SHALL have port timer_done, input, 1 bit: the move-period tick from the datapath.
REQ-010 The module SHALL have ports xpos and ypos, each input, 8 bits: the current datapath position.
REQ-011 The module SHALL have ports en_xpos and en_ypos, each output, 1 bit: datapath position register enables.
REQ-012 The module SHALL have ports s_xpos and s_ypos, each output, 2 bits: position selects (0 = init, 1 = +1, 2 = -1).
REQ-013 The module SHALL have ports s_color and plot, each output, 1 bit: colour select (1 = red, 0 = black) and the pixel write strobe.
REQ-014 The module SHALL have ports en_timer and s_timer, each output, 1 bit: timer enable and timer select (1 = count, 0 = clear).
REQ-015 The module SHALL have port move_count, output, 16 bits: the number of completed moves.

Function
REQ-016 The FSM SHALL have states INIT, DRAW, WAIT, ERASE and MOVE.
REQ-017 All datapath control outputs SHALL be 0 except where a state below asserts them.
REQ-018 INIT (1 cycle) SHALL assert en_xpos=1, s_xpos=0, en_ypos=1, s_ypos=0, en_timer=1 and s_timer=0, and SHALL go next to DRAW.
REQ-019 DRAW (1 cycle) SHALL assert plot=1, s_color=1, en_timer=1 and s_timer=0, and SHALL go next to WAIT.
REQ-020 WAIT with timer_done=0 SHALL assert en_timer=1 and s_timer=1, and SHALL remain in WAIT.
REQ-021 WAIT with timer_done=1 SHALL assert en_timer=1 and s_timer=0 (a combinational, Mealy output).
REQ-022 WAIT with timer_done=1 SHALL evaluate the keys; if a move is selected it SHALL latch the direction into an internal register and go to ERASE, otherwise it SHALL stay in WAIT.
REQ-023 A key SHALL be blocked when its move would leave the bounds: up when ypos==Y_MIN, down when ypos==Y_MAX, left when xpos==X_MIN, right when xpos==X_MAX.
REQ-024 Blocked keys SHALL be removed before priority is applied.
REQ-025 Priority among the remaining keys SHALL be up > down > left > right; exactly one direction SHALL be chosen.
REQ-026 ERASE (1 cycle) SHALL assert plot=1 and s_color=0, and SHALL go next to MOVE.
REQ-027 MOVE (1 cycle) SHALL apply the latched direction as follows, then go to DRAW:
  - up: en_ypos=1, s_ypos=2
  - down: en_ypos=1, s_ypos=1
  - left: en_xpos=1, s_xpos=2
  - right: en_xpos=1, s_xpos=1
REQ-028 In MOVE, the enable and select of the untouched axis SHALL be 0.
REQ-029 move_count SHALL increment by 1 on each exit from MOVE.
REQ-030 move_count SHALL saturate at 16'hFFFF.
REQ-031 restart=1 in any state SHALL force next state INIT and clear move_count; it SHALL override every other transition, including a WAIT/timer_done move.
REQ-032 Keys SHALL be sampled only in WAIT on timer_done=1; key changes in other states SHALL have no effect.
REQ-033 A key held continuously SHALL produce one move per timer period.
REQ-034 Exactly one plot pulse SHALL occur per DRAW state and one per ERASE state; plot SHALL never be asserted in INIT, WAIT or MOVE.

Reset
REQ-035 reset=1 SHALL asynchronously force state INIT, latched direction to up, and move_count to 0.
REQ-036 While reset=1, all control outputs SHALL be driven as for INIT.
REQ-037 After reset is released, the first edge SHALL execute INIT, followed by DRAW.
REQ-038 Reset asserted mid-ERASE or mid-MOVE SHALL abort the sequence with no further plot or position update until after INIT.

Verification
REQ-039 Release reset, no keys -> INIT and DRAW pulses in order (plot=1, s_color=1 one cycle); thereafter WAIT indefinitely with no plot pulse; move_count=0.
REQ-040 Model xpos=ypos=80; key_right held; pulse timer_done -> ERASE plot with s_color=0, then MOVE with en_xpos=1 and s_xpos=1, then DRAW; move_count=1.
REQ-041 key_up and key_left both held, ypos=Y_MIN=0 -> left is chosen (en_xpos=1, s_xpos=2); with ypos=5 -> up is chosen (en_ypos=1, s_ypos=2).
REQ-042 xpos=159, only key_right held, timer_done pulse -> stay in WAIT with no plot, en_timer=1 and s_timer=0 that cycle; move_count unchanged.
REQ-043 restart=1 in the same cycle as timer_done=1 with key_down held -> next state INIT (s_xpos=0, s_ypos=0 enables), no ERASE; move_count=0.
REQ-044 Preload move_count to 16'hFFFE by 2 moves from forced state, then 3 more moves -> move_count=16'hFFFF held; assert reset during MOVE -> outputs immediately match INIT and move_count=0.
